// File: rtl/ins_issuer.sv
// Instruction fetch/issue sequencer: program store plus IDLE/RUN/DONE issue FSM.
// Optional build macro FETCH_LOOP_EN adds a `loop` input that restarts at word 0 after the last word.
module ins_issuer #(
    parameter int INS_WIDTH  = 18,
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [INS_WIDTH-1:0]  ld_data,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  halt,
`ifdef FETCH_LOOP_EN
    input  logic                  loop,
`endif
    output logic [INS_WIDTH-1:0]  ins,
    output logic                  ins_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_DEPTH = (ADDR_WIDTH+1)'(PROG_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_LAST   = ADDR_WIDTH'(PROG_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);

    logic [INS_WIDTH-1:0]  r_mem [PROG_DEPTH];
    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [INS_WIDTH-1:0]  r_ins;
    logic                  r_ins_valid;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH:0]   w_len_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [INS_WIDTH-1:0]  w_ins_nxt;
    logic                  w_vld_nxt;
    logic [ADDR_WIDTH:0]   w_len_clip;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_last;
    logic                  w_loop;

`ifdef FETCH_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_len_clip = (prog_len > LEN_DEPTH) ? LEN_DEPTH : prog_len;
    assign w_pc_inc   = (r_pc == PC_LAST) ? '0 : r_pc + PC_ONE;
    assign w_last     = ({1'b0, r_pc} == (r_len - LEN_ONE));

    // Store has no reset; writes are locked out while a run is fetching from it.
    always_ff @(posedge clk) begin
        if (ld_en && (r_state != ST_RUN)) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_pc_nxt    = r_pc;
        w_ins_nxt   = r_ins;
        w_vld_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_len_nxt   = w_len_clip;
                    w_pc_nxt    = '0;
                    w_state_nxt = (w_len_clip == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                end else if (!stall) begin
                    w_ins_nxt = r_mem[r_pc];
                    w_vld_nxt = 1'b1;
                    w_pc_nxt  = w_pc_inc;
                    if (w_last) begin
                        if (w_loop) begin
                            w_pc_nxt = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with ins_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_pc        <= '0;
            r_ins       <= '0;
            r_ins_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_len       <= w_len_nxt;
            r_pc        <= w_pc_nxt;
            r_ins       <= w_ins_nxt;
            r_ins_valid <= w_vld_nxt;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign ins       = r_ins;
    assign ins_valid = r_ins_valid;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_ins_issuer.sv
// Self-checking bench for ins_issuer: directed scenarios plus randomized runs against a program-level model.
module tb_ins_issuer;

    localparam int INS_WIDTH  = 18;
    localparam int PROG_DEPTH = 16;
    localparam int ADDR_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  ld_en = 1'b0;
    logic [ADDR_WIDTH-1:0] ld_addr = '0;
    logic [INS_WIDTH-1:0]  ld_data = '0;
    logic [ADDR_WIDTH:0]   prog_len = '0;
    logic                  start = 1'b0;
    logic                  stall = 1'b0;
    logic                  halt = 1'b0;
`ifdef FETCH_LOOP_EN
    logic                  loop = 1'b0;
`endif
    logic [INS_WIDTH-1:0]  ins;
    logic                  ins_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int failures = 0;
    logic [INS_WIDTH-1:0] mem_m [PROG_DEPTH];
    logic [INS_WIDTH-1:0] last_ins = '0;

    ins_issuer #(
        .INS_WIDTH (INS_WIDTH),
        .PROG_DEPTH(PROG_DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .prog_len (prog_len),
        .start    (start),
        .stall    (stall),
        .halt     (halt),
`ifdef FETCH_LOOP_EN
        .loop     (loop),
`endif
        .ins      (ins),
        .ins_valid(ins_valid),
        .pc       (pc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [INS_WIDTH-1:0] data);
        ld_en   = 1'b1;
        ld_addr = ADDR_WIDTH'(addr);
        ld_data = data;
        cyc();
        ld_en   = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic quiet();
        ld_en = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0;
    endtask

    // One run: the issued stream must be mem_m[0..min(L,16)-1] in order, skipping stalled cycles.
    task automatic run_check(input int L, input logic [63:0] smask, input int halt_at,
                             input int rst_at, input bit noise);
        int lc;
        int issued;
        int c;
        lc = (L > PROG_DEPTH) ? PROG_DEPTH : L;
        issued = 0;
        c = 0;
        prog_len = (ADDR_WIDTH+1)'(L);
        start = 1'b1;
        cyc();
        quiet();
        chk("start_busy", busy, lc > 0);
        chk("start_done", done, lc == 0);
        chk("start_vld", ins_valid, 0);
        chk("start_pc", pc, 0);
        chk("start_ins", ins, last_ins);
        while (issued < lc && c < lc + 80) begin
            if (issued == halt_at) begin
                halt  = 1'b1;
                stall = 1'($urandom_range(0, 1));
                cyc();
                quiet();
                chk("halt_busy", busy, 0);
                chk("halt_done", done, 0);
                chk("halt_vld", ins_valid, 0);
                chk("halt_pc", pc, 0);
                chk("halt_ins", ins, last_ins);
                cyc();
                chk("halt_stays_idle", busy, 0);
                return;
            end
            if (issued == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_vld", ins_valid, 0);
                chk("rst_pc", pc, 0);
                chk("rst_ins", ins, 0);
                last_ins = '0;
                cyc();
                rst = 1'b0;
                return;
            end
            stall = (c < 64) ? smask[c] : 1'b0;
            if (noise) begin
                ld_en    = 1'($urandom_range(0, 1));
                ld_addr  = ADDR_WIDTH'($urandom);
                ld_data  = INS_WIDTH'($urandom);
                start    = 1'($urandom_range(0, 1));
                prog_len = (ADDR_WIDTH+1)'($urandom);
            end
            cyc();
            c++;
            if (stall) begin
                chk("stall_vld", ins_valid, 0);
                chk("stall_ins", ins, last_ins);
                chk("stall_pc", pc, issued % PROG_DEPTH);
                chk("stall_busy", busy, 1);
                chk("stall_done", done, 0);
            end else begin
                chk("issue_vld", ins_valid, 1);
                chk("issue_ins", ins, mem_m[issued]);
                last_ins = mem_m[issued];
                issued++;
                chk("issue_pc", pc, issued % PROG_DEPTH);
                chk("issue_busy", busy, issued < lc);
                chk("issue_done", done, issued == lc);
            end
        end
        quiet();
        if (issued < lc) chk("run_timeout", issued, lc);
        cyc();
        chk("end_vld", ins_valid, 0);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_ins", ins, last_ins);
        chk("end_pc", pc, lc % PROG_DEPTH);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_ins", ins, 0);
        chk("reset_vld", ins_valid, 0);
        chk("reset_pc", pc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Basic three-word program
        load(0, 18'b000_00000_00010_00001);
        load(1, 18'b001_00011_00001_00010);
        load(2, 18'b110_00100_00001_00011);
        run_check(3, 64'd0, -1, -1, 1'b0);

        // Two stall cycles after the first issue
        run_check(3, 64'b110, -1, -1, 1'b0);

        // Zero length goes straight to DONE
        run_check(0, 64'd0, -1, -1, 1'b0);

        // Oversize length clips to the store depth and wraps pc
        for (int i = 0; i < PROG_DEPTH; i++) load(i, INS_WIDTH'($urandom));
        run_check(20, 64'd0, -1, -1, 1'b0);

        // Halt, then reset, after the second issue; store must survive
        run_check(5, 64'd0, 2, -1, 1'b0);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt_idle_ignored_busy", busy, 0);
        chk("halt_idle_ignored_done", done, 0);
        run_check(5, 64'd0, -1, 2, 1'b0);
        run_check(5, 64'd0, -1, -1, 1'b0);

        // Loads and starts during RUN are ignored
        run_check(16, {$urandom, $urandom} & {$urandom, $urandom}, -1, -1, 1'b1);
        run_check(16, 64'd0, -1, -1, 1'b0);

        // Halt in DONE is ignored
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt_done_ignored", done, 1);

        // Write and start in the same cycle: the run sees the new word
        ld_en   = 1'b1;
        ld_addr = '0;
        ld_data = 18'h2A5A5;
        mem_m[0] = 18'h2A5A5;
        run_check(2, 64'd0, -1, -1, 1'b0);

        // Randomized programs, lengths, stalls and bus noise
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) load($urandom_range(0, PROG_DEPTH - 1), INS_WIDTH'($urandom));
            run_check($urandom_range(0, 20), {$urandom, $urandom} & {$urandom, $urandom},
                      -1, -1, 1'($urandom_range(0, 1)));
        end

`ifdef FETCH_LOOP_EN
        loop = 1'b1;
        prog_len = 5'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("loop_vld", ins_valid, 1);
            chk("loop_ins", ins, mem_m[i % 2]);
            chk("loop_busy", busy, 1);
        end
        loop = 1'b0;
        cyc();
        chk("loop_exit_ins0", ins, mem_m[0]);
        cyc();
        chk("loop_exit_ins1", ins, mem_m[1]);
        chk("loop_exit_done", done, 1);
        last_ins = mem_m[1];
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ins_issuer.md
Name: ins_issuer

Overview:
- Instruction fetch/issue sequencer; the producing end of the instruction word the datapath core consumes on its `ins` input.
- Holds a small program store, loaded through a write port.
- On start, drives one instruction word per clock to the core, honouring stall and halt.
- Reports busy and done to the bench or host.

Parameters:
- INS_WIDTH, 18, instruction word width (3 opcode + 3×5 register fields).
- PROG_DEPTH, 16, number of program store entries.
- ADDR_WIDTH, $clog2(PROG_DEPTH), program counter and load address width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- ld_en  input  1  program store write strobe.
- ld_addr  input  ADDR_WIDTH  program store write address.
- ld_data  input  INS_WIDTH  program store write data.
- prog_len  input  ADDR_WIDTH+1  number of instructions to issue; sampled on accepted start.
- start  input  1  begin issuing from address 0.
- stall  input  1  hold issue this cycle.
- halt  input  1  abort the run.
- ins  output  INS_WIDTH  instruction word to the core.
- ins_valid  output  1  ins is a new instruction this cycle.
- pc  output  ADDR_WIDTH  address of the next instruction to issue.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst).
- Reset (async, immediate):
  - state=IDLE, pc=0, ins=0, ins_valid=0, busy=0, done=0.
  - Latched length = 0.
  - Program store contents are not reset.
- States: IDLE, RUN, DONE. busy and done are registered and decode the state: busy=(RUN), done=(DONE).
- Load:
  - ld_en writes mem[ld_addr] <= ld_data at posedge, in IDLE or DONE only.
  - ld_en in RUN is ignored; the store is unchanged.
- IDLE/DONE + start:
  - Latch len = min(prog_len, PROG_DEPTH); pc <= 0.
  - If len==0: go to (or stay in) DONE; no ins_valid.
  - Else go to RUN.
  - start and ld_en in the same cycle: the write completes, and the run issues the new data if the address is later fetched.
- RUN, per posedge, priority halt > stall > issue:
  - halt: state <= IDLE, ins_valid <= 0, pc <= 0, ins holds.
  - stall: ins holds, ins_valid <= 0, pc holds.
  - issue: ins <= mem[pc], ins_valid <= 1, pc <= pc+1 (wraps to 0 at PROG_DEPTH).
  - If the issue has pc == len-1: state <= DONE.
- start in RUN is ignored. halt outside RUN is ignored.
- Latency:
  - start sampled at edge k gives the first ins_valid after edge k+1.
  - Unstalled, len instructions on consecutive cycles.
  - done rises on the edge that issues the last word, so done and the last ins_valid appear together.
- DONE:
  - ins holds the last word, ins_valid=0.
  - Remains until start or rst.
- ins_valid is a one-cycle qualifier per issued word; the core samples ins whenever ins_valid=1.
- Reset mid-RUN: immediate return to reset values; the program store is retained.

Optional Feature:
- Macro FETCH_LOOP_EN.
- Defined:
  - Adds input `loop` (1 bit).
  - On the issue with pc == len-1 while loop=1: pc <= 0 and the block stays in RUN, issuing continuously until halt, or until loop=0 at the last word.
- Undefined:
  - No `loop` port; the last word always goes to DONE.

Test Plan:
- Load mem[0..2]={'b000_00000_00010_00001,'b001_00011_00001_00010,'b110_00100_00001_00011}, prog_len=3, start pulse -> ins_valid on 3 consecutive cycles with those words in order; pc 0→1→2→3; done=1 with the third word; busy then 0.
- Same program, stall=1 for 2 cycles after the first issue -> ins holds word0 with ins_valid=0 for 2 cycles; then words 1 and 2; 3 valid pulses total.
- prog_len=0, start -> DONE next cycle; no ins_valid; busy never 1.
- prog_len=20 with PROG_DEPTH=16 -> exactly 16 issues; pc wraps to 0; done.
- halt, and separately rst, asserted after the 2nd issue -> IDLE, pc=0, ins_valid=0.
  - After rst, restart with start issues the original mem contents (store retained).
  - ld_en during RUN leaves the store unchanged.
- FETCH_LOOP_EN defined: loop=1, len=2 -> words 0,1,0,1,… until halt; with loop=0 at the second word -> DONE.
